// File: rtl/beat_clock_gen.sv
// Tempo source: captures a clamped BPM, divides CLK_HZ*30 by it to get the
// eighth-note period, then emits a run-gated tick and slow_clk square wave.
module beat_clock_gen #(
   parameter int CLK_HZ  = 50000000,
   parameter int CNT_W   = 32,
   parameter int BPM_W   = 8,
   parameter int MIN_BPM = 30,
   parameter int MAX_BPM = 240
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_bpm,
   input  logic [BPM_W-1:0] bpm_in,
   input  logic             run,
   output logic             tick,
   output logic             slow_clk,
   output logic             busy,
   output logic [BPM_W-1:0] bpm_q,
   output logic             bpm_err
);
   localparam int               IT_W     = $clog2(CNT_W + 1);
   localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(64'(CLK_HZ) * 64'd30);
   localparam logic [BPM_W-1:0] MIN_B    = BPM_W'(MIN_BPM);
   localparam logic [BPM_W-1:0] MAX_B    = BPM_W'(MAX_BPM);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_READY} state_t;

   state_t           r_state;
   logic             r_tick, r_slow, r_busy, r_bpm_err;
   logic [BPM_W-1:0] r_bpm_q;
   logic [CNT_W-1:0] r_period, r_cnt, r_rem, r_quo;
   logic [IT_W-1:0]  r_iter;

   logic             w_lo, w_hi, w_fits;
   logic [BPM_W-1:0] w_clamp;
   logic [CNT_W:0]   w_divisor, w_rem_sh;
   logic [CNT_W-1:0] w_diff;

   assign w_lo    = bpm_in < MIN_B;
   assign w_hi    = bpm_in > MAX_B;
   assign w_clamp = w_lo ? MIN_B : (w_hi ? MAX_B : bpm_in);

   // One restoring-division step: shift the next dividend bit into the remainder.
   assign w_divisor = {{(CNT_W + 1 - BPM_W){1'b0}}, r_bpm_q};
   assign w_rem_sh  = {r_rem, r_quo[CNT_W-1]};
   assign w_fits    = w_rem_sh >= w_divisor;
   assign w_diff    = w_rem_sh[CNT_W-1:0] - w_divisor[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tick    <= 1'b0;
         r_slow    <= 1'b0;
         r_busy    <= 1'b0;
         r_bpm_q   <= '0;
         r_bpm_err <= 1'b0;
         r_period  <= '0;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_iter    <= '0;
      end else if (ld_bpm) begin
         r_state   <= S_DIV;
         r_bpm_q   <= w_clamp;
         r_bpm_err <= w_lo | w_hi;
         r_busy    <= 1'b1;
         r_tick    <= 1'b0;
         r_slow    <= 1'b0;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= DIVIDEND;
         r_iter    <= '0;
      end else begin
         case (r_state)
            S_DIV: begin
               r_tick <= 1'b0;
               r_slow <= 1'b0;
               if (r_iter == IT_W'(CNT_W)) begin
                  r_period <= r_quo;
                  r_cnt    <= '0;
                  r_busy   <= 1'b0;
                  r_state  <= S_READY;
               end else begin
                  r_iter <= r_iter + IT_W'(1);
                  r_rem  <= w_fits ? w_diff : w_rem_sh[CNT_W-1:0];
                  r_quo  <= {r_quo[CNT_W-2:0], w_fits};
               end
            end
            S_READY: begin
               if (run) begin
                  r_tick <= (r_cnt == '0);
                  r_slow <= (r_cnt < (r_period >> 1));
                  r_cnt  <= (r_cnt == r_period - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);
               end else begin
                  // Pausing drops the partial beat; resuming starts a fresh one.
                  r_tick <= 1'b0;
                  r_slow <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            default: begin
               r_tick <= 1'b0;
               r_slow <= 1'b0;
            end
         endcase
      end
   end

   assign tick     = r_tick;
   assign slow_clk = r_slow;
   assign busy     = r_busy;
   assign bpm_q    = r_bpm_q;
   assign bpm_err  = r_bpm_err;
endmodule

// File: tb/tb_beat_clock_gen.sv
// Bench for beat_clock_gen at CLK_HZ=1600, CNT_W=16: directed scenarios plus
// random traffic, all compared cycle by cycle against an event-timeline model.
module tb_beat_clock_gen;
   localparam int CNT_W    = 16;
   localparam int DIVIDEND = 1600 * 30;

   logic       clk = 1'b0, reset = 1'b1, ld_bpm = 1'b0, run = 1'b0;
   logic [7:0] bpm_in = '0;
   logic       tick, slow_clk, busy, bpm_err;
   logic [7:0] bpm_q;

   always #5 clk = ~clk;

   beat_clock_gen #(.CLK_HZ(1600), .CNT_W(CNT_W), .BPM_W(8), .MIN_BPM(30), .MAX_BPM(240)) dut (
      .clk(clk), .reset(reset), .ld_bpm(ld_bpm), .bpm_in(bpm_in), .run(run),
      .tick(tick), .slow_clk(slow_clk), .busy(busy), .bpm_q(bpm_q), .bpm_err(bpm_err)
   );

   int n = 0, n_chk = 0, n_pass = 0;

   // Model: remembers when the divide ends and when continuous play began;
   // beat phase is (now - play_start) mod period.
   bit         m_div = 0, m_valid = 0;
   int         m_end = 0, m_period = 1, m_play = -1;
   logic [7:0] m_bpm = '0;
   logic       m_err = 0, m_busy = 0, m_tick = 0, m_slow = 0;

   wire [11:0] w_obs = {busy, tick, slow_clk, bpm_err, bpm_q};
   wire [11:0] w_exp = {m_busy, m_tick, m_slow, m_err, m_bpm};

   task automatic cyc();
      int k;
      @(posedge clk);
      n++;
      m_busy = 0; m_tick = 0; m_slow = 0;
      if (reset) begin
         m_div = 0; m_valid = 0; m_play = -1; m_bpm = '0; m_err = 0;
      end else if (ld_bpm) begin
         m_bpm   = (bpm_in < 30) ? 8'd30 : (bpm_in > 240) ? 8'd240 : bpm_in;
         m_err   = (bpm_in < 30) || (bpm_in > 240);
         m_div   = 1; m_end = n + CNT_W + 1; m_valid = 0; m_play = -1; m_busy = 1;
      end else if (m_div) begin
         if (n < m_end) m_busy = 1;
         else begin
            m_div = 0; m_valid = 1; m_period = DIVIDEND / int'(m_bpm); m_play = -1;
         end
      end else if (m_valid) begin
         if (run) begin
            if (m_play < 0) m_play = n;
            k = (n - m_play) % m_period;
            m_tick = (k == 0);
            m_slow = (k < m_period / 2);
         end else m_play = -1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1; cyc(); cyc();
      n_chk++; if (w_obs !== 12'h000) $display("FAIL reset_zero got=%h want=000", w_obs); else n_pass++;
      n_chk++; if (w_obs !== w_exp) $display("FAIL reset_model got=%h want=%h", w_obs, w_exp); else n_pass++;
      reset = 0; cyc();
   endtask

   task automatic test_nominal();
      int bc, t1 = -1, t2 = -1, hi = 0, nl;
      bpm_in = 8'd120; ld_bpm = 1; run = 1; cyc(); ld_bpm = 0; nl = n; bc = busy;
      repeat (1000) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL nominal_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
         bc += busy;
         if (tick) begin if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n; end
         if (t1 >= 0 && t2 < 0 && slow_clk) hi++;
      end
      n_chk++; if (bc !== 17) $display("FAIL nominal_busy got=%0d want=17", bc); else n_pass++;
      n_chk++; if (t1 !== nl + 18) $display("FAIL nominal_first_tick got=%0d want=%0d", t1 - nl, 18); else n_pass++;
      n_chk++; if (t2 - t1 !== 400) $display("FAIL nominal_spacing got=%0d want=400", t2 - t1); else n_pass++;
      n_chk++; if (hi !== 200) $display("FAIL nominal_slow_hi got=%0d want=200", hi); else n_pass++;
      n_chk++; if ({bpm_err, bpm_q} !== {1'b0, 8'd120}) $display("FAIL nominal_bpm got=%0d/%0d want=0/120", bpm_err, bpm_q); else n_pass++;
   endtask

   task automatic test_clamp();
      int tb_in[3] = '{0, 255, 200};
      int tb_q[3]  = '{30, 240, 200};
      int tb_e[3]  = '{1, 1, 0};
      int tb_p[3]  = '{1600, 200, 240};
      for (int e = 0; e < 3; e++) begin
         int t1 = -1, t2 = -1;
         bpm_in = 8'(tb_in[e]); ld_bpm = 1; run = 1; cyc(); ld_bpm = 0;
         for (int i = 0; i < 2 * tb_p[e] + 40; i++) begin
            cyc();
            n_chk++; if (w_obs !== w_exp) $display("FAIL clamp_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
            if (tick) begin if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n; end
         end
         n_chk++; if (int'(bpm_q) !== tb_q[e]) $display("FAIL clamp_q in=%0d got=%0d want=%0d", tb_in[e], bpm_q, tb_q[e]); else n_pass++;
         n_chk++; if (int'(bpm_err) !== tb_e[e]) $display("FAIL clamp_err in=%0d got=%0d want=%0d", tb_in[e], bpm_err, tb_e[e]); else n_pass++;
         n_chk++; if (t2 - t1 !== tb_p[e]) $display("FAIL clamp_period in=%0d got=%0d want=%0d", tb_in[e], t2 - t1, tb_p[e]); else n_pass++;
      end
   endtask

   task automatic test_run_gating();
      bit found = 0;
      int ticks = 0, gap = 0;
      bpm_in = 8'd240; ld_bpm = 1; run = 1; cyc(); ld_bpm = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL gate_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
         if (tick) found = 1;
      end
      n_chk++; if (!found) $display("FAIL gate_first_tick got=none want=tick"); else n_pass++;
      repeat (149) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL gate_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      run = 0;
      repeat (50) begin
         cyc(); ticks += tick + slow_clk;
         n_chk++; if (w_obs !== w_exp) $display("FAIL gate_off n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      n_chk++; if (ticks !== 0) $display("FAIL gate_quiet got=%0d want=0", ticks); else n_pass++;
      run = 1; cyc();
      n_chk++; if ({tick, slow_clk} !== 2'b11) $display("FAIL gate_restart got=%b want=11", {tick, slow_clk}); else n_pass++;
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         cyc(); gap++;
         n_chk++; if (w_obs !== w_exp) $display("FAIL gate_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
         if (tick) found = 1;
      end
      n_chk++; if (gap !== 200) $display("FAIL gate_gap got=%0d want=200", gap); else n_pass++;
   endtask

   task automatic test_reload();
      int bc, bad = 0, t1 = -1, t2 = -1, nl;
      run = 1; bpm_in = 8'd60; ld_bpm = 1; cyc(); ld_bpm = 0;
      repeat (7) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL reload_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      bpm_in = 8'd120; ld_bpm = 1; cyc(); ld_bpm = 0; nl = n; bc = busy;
      repeat (900) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL reload_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
         bc += busy;
         if (busy && (tick || slow_clk)) bad++;
         if (tick) begin if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n; end
      end
      n_chk++; if (bc !== 17) $display("FAIL reload_busy got=%0d want=17", bc); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL reload_tick_in_busy got=%0d want=0", bad); else n_pass++;
      n_chk++; if (t1 !== nl + 18) $display("FAIL reload_first_tick got=%0d want=18", t1 - nl); else n_pass++;
      n_chk++; if (t2 - t1 !== 400) $display("FAIL reload_spacing got=%0d want=400", t2 - t1); else n_pass++;
   endtask

   task automatic test_tempo_change();
      int last_b = -1, bad = 0, t1 = -1, t2 = -1;
      bpm_in = 8'd240; ld_bpm = 1; cyc(); ld_bpm = 0;
      last_b = n;
      repeat (500) begin
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL tempo_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
         if (busy) begin last_b = n; if (tick || slow_clk) bad++; end
         else if (tick) begin if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n; end
      end
      n_chk++; if (bad !== 0) $display("FAIL tempo_quiet got=%0d want=0", bad); else n_pass++;
      n_chk++; if (t1 !== last_b + 2) $display("FAIL tempo_first_tick got=%0d want=%0d", t1, last_b + 2); else n_pass++;
      n_chk++; if (t2 - t1 !== 200) $display("FAIL tempo_spacing got=%0d want=200", t2 - t1); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int ticks = 0, seen = 0;
      run = 0; bpm_in = 8'd120; ld_bpm = 1; cyc(); ld_bpm = 0;
      repeat (5) cyc();
      reset = 1; cyc(); reset = 0;
      n_chk++; if (w_obs !== 12'h000) $display("FAIL rst_div got=%h want=000", w_obs); else n_pass++;
      run = 1;
      repeat (60) begin
         cyc(); ticks += tick + busy;
         n_chk++; if (w_obs !== w_exp) $display("FAIL rst_idle n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      n_chk++; if (ticks !== 0) $display("FAIL rst_idle_quiet got=%0d want=0", ticks); else n_pass++;
      ld_bpm = 1; cyc(); ld_bpm = 0;
      repeat (30) begin cyc(); seen += tick; end
      n_chk++; if (seen !== 1) $display("FAIL rst_play_tick got=%0d want=1", seen); else n_pass++;
      reset = 1; cyc(); reset = 0;
      n_chk++; if (w_obs !== 12'h000) $display("FAIL rst_play got=%h want=000", w_obs); else n_pass++;
      ticks = 0;
      repeat (40) begin
         cyc(); ticks += tick;
         n_chk++; if (w_obs !== w_exp) $display("FAIL rst_after n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      n_chk++; if (ticks !== 0) $display("FAIL rst_after_quiet got=%0d want=0", ticks); else n_pass++;
   endtask

   task automatic test_random();
      run = 1; bpm_in = 8'($urandom_range(0, 255)); ld_bpm = 1; cyc(); ld_bpm = 0;
      for (int i = 0; i < 4000; i++) begin
         ld_bpm = ($urandom_range(0, 249) == 0);
         if (ld_bpm) bpm_in = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 79) == 0) run = ~run;
         reset = ($urandom_range(0, 1499) == 0);
         cyc();
         n_chk++; if (w_obs !== w_exp) $display("FAIL random_cyc n=%0d got=%h want=%h", n, w_obs, w_exp); else n_pass++;
      end
      reset = 0; ld_bpm = 0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_clamp();
      test_run_gating();
      test_reload();
      test_tempo_change();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
